// File: rtl/subtrator_serial_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t        : FSM encoding (IDLE, LOAD, SHIFT, FIN)
//   SUB_WIDTH      : default operand/result width used by the top-level wiring
package subtrator_serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      FIN   = 2'd3
   } state_t;

   localparam int SUB_WIDTH = 4;

endpackage

// File: rtl/subtrator_serial_sub.sv
// subtrator1bit: combinational full subtractor, d = a - b - bin.
// Ports:
//   a, b  in  minuend / subtrahend bit
//   bin   in  borrow in
//   d     out difference bit
//   bout  out borrow out
module subtrator1bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   // Borrow when a < b, or when a == b and a borrow is already pending.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtrator_serial.sv
// subtrator_serial: bit-serial N-bit subtractor, D = A - B, LSB first.
// One bit per SHIFT cycle through a single subtrator1bit stage and a
// one-bit borrow register. D drives the board's hex decoder path and
// BORROW drives an LED; that wiring lives in the board top.
//
// Optional feature macro: SUBTRATOR_SIGNED_EN
//   defined   : OVF reports signed overflow of the finished subtraction
//   undefined : OVF is tied to 0 (port list unchanged)
//
// Ports:
//   CLOCK_50  in   system clock, rising edge
//   RST       in   synchronous active-high reset
//   START     in   request, honoured only in IDLE
//   A, B      in   operands, captured when START is accepted
//   BUSY      out  high in LOAD and SHIFT
//   DONE      out  one-cycle pulse in FIN
//   D         out  A - B mod 2^N, held until the next result
//   BORROW    out  1 iff unsigned A < B, held with D
//   OVF       out  signed overflow flag
//
// Handshake: START is sampled on a rising edge only while in IDLE; once
// accepted, further START pulses are ignored (not queued) until the FSM is
// back in IDLE. DONE marks the single cycle in which D/BORROW/OVF first hold
// the new result.
module subtrator_serial
   import subtrator_serial_pkg::*;
#(
   parameter int N = SUB_WIDTH
) (
   input  logic         CLOCK_50,
   input  logic         RST,
   input  logic         START,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         BUSY,
   output logic         DONE,
   output logic [N-1:0] D,
   output logic         BORROW,
   output logic         OVF
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   state_t        state, state_next;
   logic [N-1:0]  a_r, b_r, res;
   logic          bw;
   logic [CW-1:0] cnt;
   logic          d_bit, bout_bit;
   logic [N-1:0]  res_shift;
   logic          last_bit;

   subtrator1bit u_sub (
      .a    (a_r[0]),
      .b    (b_r[0]),
      .bin  (bw),
      .d    (d_bit),
      .bout (bout_bit)
   );

   assign res_shift = {d_bit, res[N-1:1]};
   assign last_bit  = (cnt == CNT_LAST);

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (START) state_next = LOAD;
         LOAD:    state_next = SHIFT;
         SHIFT:   if (last_bit) state_next = FIN;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign BUSY = (state == LOAD) || (state == SHIFT);
   assign DONE = (state == FIN);

   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath. Operands are captured on the accepting edge so that A/B may
   // change freely while the operation runs; LOAD then clears the
   // accumulation state before the first SHIFT.
   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         a_r    <= '0;
         b_r    <= '0;
         res    <= '0;
         bw     <= 1'b0;
         cnt    <= '0;
         D      <= '0;
         BORROW <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  a_r <= A;
                  b_r <= B;
               end
            end
            LOAD: begin
               bw  <= 1'b0;
               cnt <= '0;
               res <= '0;
            end
            SHIFT: begin
               res <= res_shift;
               a_r <= a_r >> 1;
               b_r <= b_r >> 1;
               bw  <= bout_bit;
               cnt <= cnt + 1'b1;
               // Results are published only on the final bit, so outputs
               // never show a partially shifted value.
               if (last_bit) begin
                  D      <= res_shift;
                  BORROW <= bout_bit;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SUBTRATOR_SIGNED_EN
   // Operand sign bits are kept separately because a_r/b_r are shifted out.
   logic a_msb, b_msb;
   logic ovf_r;

   always_ff @(posedge CLOCK_50) begin
      if (RST) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf_r <= 1'b0;
      end else begin
         if (state == IDLE && START) begin
            a_msb <= A[N-1];
            b_msb <= B[N-1];
         end
         // On the last bit d_bit is the result's sign bit.
         if (state == SHIFT && last_bit) begin
            ovf_r <= (a_msb ^ b_msb) & (a_msb ^ d_bit);
         end
      end
   end

   assign OVF = ovf_r;
`else
   assign OVF = 1'b0;
`endif

endmodule
